// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared widths, mode encodings and scheduler state for the ECC job scheduler
package ecc_pkg;

    // Widest operand the scheduler and engine carry
    localparam int MAX_BITS = 256;

    // Width-mode encodings forwarded to the engine on eng_mode
    localparam logic [1:0] BITS32  = 2'b00;
    localparam logic [1:0] BITS64  = 2'b01;
    localparam logic [1:0] BITS128 = 2'b10;
    localparam logic [1:0] BITS256 = 2'b11;

    // Scheduler states; at most one job is in flight at any time
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with a last-grant register
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_update_id,
    output logic [1:0] o_grant
);

    // r_served stays 0 until the first job completes, so requester 0
    // keeps priority out of reset even though r_last also resets to 0.
    logic r_last;
    logic r_served;

    // Record which requester was served once its response is consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last   <= 1'b0;
            r_served <= 1'b0;
        end else if (i_update) begin
            r_last   <= i_update_id;
            r_served <= 1'b1;
        end
    end

    // One-hot grant; on contention the requester not served last wins
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_served && !r_last) ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ecc_job_scheduler.sv
// rtl/ecc_job_scheduler.sv - arbitrates two requesters onto one ECC point-multiply engine with watchdog
module ecc_job_scheduler #(
    parameter int MAX_BITS = 256,
    parameter int TIMEOUT  = 1048575
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [1:0]            cfg_mode,
    input  logic [MAX_BITS-1:0]   cfg_a,
    input  logic [MAX_BITS-1:0]   cfg_b,
    input  logic [MAX_BITS-1:0]   cfg_prime,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*MAX_BITS-1:0] req_px,
    input  logic [2*MAX_BITS-1:0] req_py,
    input  logic [2*MAX_BITS-1:0] req_k,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [MAX_BITS-1:0]   rsp_x,
    output logic [MAX_BITS-1:0]   rsp_y,
    output logic                  rsp_err,
    output logic                  eng_valid,
    output logic [1:0]            eng_mode,
    output logic [MAX_BITS-1:0]   eng_a,
    output logic [MAX_BITS-1:0]   eng_b,
    output logic [MAX_BITS-1:0]   eng_prime,
    output logic [MAX_BITS-1:0]   eng_k,
    output logic [MAX_BITS-1:0]   eng_px,
    output logic [MAX_BITS-1:0]   eng_py,
    input  logic                  eng_finished,
    input  logic [MAX_BITS-1:0]   eng_outx,
    input  logic [MAX_BITS-1:0]   eng_outy,
    output logic                  busy
);

    import ecc_pkg::*;

    // Watchdog wide enough to hold TIMEOUT-1; it expires on that value
    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_t          r_state;
    logic                  r_eng_valid;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_id;
    logic                  r_busy;
    logic [WD_W-1:0]       r_wd;
    logic [MAX_BITS-1:0]   r_px;
    logic [MAX_BITS-1:0]   r_py;
    logic [MAX_BITS-1:0]   r_k;
    logic [MAX_BITS-1:0]   r_rsp_x;
    logic [MAX_BITS-1:0]   r_rsp_y;
    logic [1:0]            r_cfg_mode;
    logic [MAX_BITS-1:0]   r_cfg_a;
    logic [MAX_BITS-1:0]   r_cfg_b;
    logic [MAX_BITS-1:0]   r_cfg_prime;

    logic [1:0]            w_grant;
    logic                  w_gid;
    logic                  w_take;
    logic                  w_rsp_done;
    logic [MAX_BITS-1:0]   w_sel_px;
    logic [MAX_BITS-1:0]   w_sel_py;
    logic [MAX_BITS-1:0]   w_sel_k;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req_valid),
        .i_update    (w_rsp_done),
        .i_update_id (r_id),
        .o_grant     (w_grant)
    );

    // Ready only exposes the arbiter's grant while idle; it is gated by
    // reset so nothing looks accepted while rst is held low.
    assign req_ready  = (rst && (r_state == ST_IDLE)) ? w_grant : 2'b00;
    assign w_take     = |(req_valid & req_ready);
    assign w_gid      = w_grant[1];
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;

    // Requester i's operands live in slice i of the packed request buses
    assign w_sel_px = w_gid ? req_px[2*MAX_BITS-1:MAX_BITS] : req_px[MAX_BITS-1:0];
    assign w_sel_py = w_gid ? req_py[2*MAX_BITS-1:MAX_BITS] : req_py[MAX_BITS-1:0];
    assign w_sel_k  = w_gid ? req_k[2*MAX_BITS-1:MAX_BITS]  : req_k[MAX_BITS-1:0];

    // Curve configuration is only writable while no job is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_mode  <= 2'b00;
            r_cfg_a     <= '0;
            r_cfg_b     <= '0;
            r_cfg_prime <= '0;
        end else if (cfg_valid && (r_state == ST_IDLE)) begin
            r_cfg_mode  <= cfg_mode;
            r_cfg_a     <= cfg_a;
            r_cfg_b     <= cfg_b;
            r_cfg_prime <= cfg_prime;
        end
    end

    // Job FSM: accept, run the engine under a watchdog, hold the response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_eng_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_id        <= 1'b0;
            r_busy      <= 1'b0;
            r_wd        <= '0;
            r_px        <= '0;
            r_py        <= '0;
            r_k         <= '0;
            r_rsp_x     <= '0;
            r_rsp_y     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_px   <= w_sel_px;
                        r_py   <= w_sel_py;
                        r_k    <= w_sel_k;
                        r_id   <= w_gid;
                        r_wd   <= '0;
                        r_busy <= 1'b1;
                        if (w_sel_k == '0) begin
                            // k*P with k=0 is the point at infinity; no engine run needed
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_x     <= '0;
                            r_rsp_y     <= '0;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_state     <= ST_RUN;
                            r_eng_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Completion is checked first so a finish on the last
                    // watchdog cycle still returns a good result.
                    if (eng_finished) begin
                        r_state     <= ST_RESP;
                        r_eng_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_x     <= eng_outx;
                        r_rsp_y     <= eng_outy;
                        r_rsp_err   <= 1'b0;
                    end else if (r_wd == WD_LAST) begin
                        r_state     <= ST_RESP;
                        r_eng_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_x     <= '0;
                        r_rsp_y     <= '0;
                        r_rsp_err   <= 1'b1;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_eng_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign eng_valid = r_eng_valid;
    assign eng_mode  = r_cfg_mode;
    assign eng_a     = r_cfg_a;
    assign eng_b     = r_cfg_b;
    assign eng_prime = r_cfg_prime;
    assign eng_k     = r_k;
    assign eng_px    = r_px;
    assign eng_py    = r_py;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_x     = r_rsp_x;
    assign rsp_y     = r_rsp_y;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ecc_job_scheduler.sv
// tb/tb_ecc_job_scheduler.sv - randomized self-checking bench for ecc_job_scheduler
module tb_ecc_job_scheduler;

    localparam int MB = 256;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic [1:0]    cfg_mode;
    logic [MB-1:0] cfg_a, cfg_b, cfg_prime;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [2*MB-1:0] req_px, req_py, req_k;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [MB-1:0] rsp_x, rsp_y;
    logic          eng_valid;
    logic [1:0]    eng_mode;
    logic [MB-1:0] eng_a, eng_b, eng_prime, eng_k, eng_px, eng_py;
    logic          eng_finished;
    logic [MB-1:0] eng_outx, eng_outy;
    logic          busy;

    logic [MB-1:0] px_a [2];
    logic [MB-1:0] py_a [2];
    logic [MB-1:0] kk_a [2];
    assign req_px = {px_a[1], px_a[0]};
    assign req_py = {py_a[1], py_a[0]};
    assign req_k  = {kk_a[1], kk_a[0]};

    int n_pass  = 0;
    int n_total = 0;

    // Round-robin reference: who was served last, and whether anyone was yet
    int served_any = 0;
    int last_served = 0;

    // Engine stand-in: finishes on its eng_lat-th run cycle (0 = never)
    int            eng_lat = 0;
    int            eng_cnt = 0;
    bit            eng_fixed = 0;
    logic [MB-1:0] fixed_x, fixed_y;
    logic          eng_fin_m = 1'b0;
    logic          spur_fin = 1'b0;
    assign eng_finished = eng_fin_m | spur_fin;

    ecc_job_scheduler #(.MAX_BITS(MB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_prime(cfg_prime),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_px(req_px), .req_py(req_py), .req_k(req_k),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err),
        .eng_valid(eng_valid), .eng_mode(eng_mode), .eng_a(eng_a), .eng_b(eng_b),
        .eng_prime(eng_prime), .eng_k(eng_k), .eng_px(eng_px), .eng_py(eng_py),
        .eng_finished(eng_finished), .eng_outx(eng_outx), .eng_outy(eng_outy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [MB-1:0] rand256();
        logic [MB-1:0] v;
        for (int i = 0; i < MB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    always @(negedge clk) begin
        if (eng_valid) begin
            eng_cnt = eng_cnt + 1;
            if (eng_lat != 0 && eng_cnt == eng_lat) begin
                eng_fin_m = 1'b1;
                eng_outx  = eng_fixed ? fixed_x : (eng_px ^ eng_k);
                eng_outy  = eng_fixed ? fixed_y : (eng_py + eng_k);
            end else begin
                eng_fin_m = 1'b0;
                eng_outx  = rand256();
                eng_outy  = rand256();
            end
        end else begin
            eng_cnt   = 0;
            eng_fin_m = 1'b0;
            eng_outx  = rand256();
            eng_outy  = rand256();
        end
    end

    // Reference rules: zero scalar short-circuits, otherwise the engine
    // result arrives lat+1 cycles after acceptance unless the watchdog
    // (TO run cycles) expires first.
    function automatic bit m_timeout(logic [MB-1:0] k, int lat);
        return (k != 0) && !(lat >= 1 && lat <= TO);
    endfunction
    function automatic int m_lat(logic [MB-1:0] k, int lat);
        if (k == 0) return 1;
        if (lat >= 1 && lat <= TO) return lat + 1;
        return TO + 1;
    endfunction
    function automatic int m_engcnt(logic [MB-1:0] k, int lat);
        return m_lat(k, lat) - 1;
    endfunction
    function automatic logic [MB-1:0] m_x(logic [MB-1:0] p, logic [MB-1:0] k, int lat);
        return (k == 0 || m_timeout(k, lat)) ? '0 : (p ^ k);
    endfunction
    function automatic logic [MB-1:0] m_y(logic [MB-1:0] p, logic [MB-1:0] k, int lat);
        return (k == 0 || m_timeout(k, lat)) ? '0 : (p + k);
    endfunction
    function automatic int m_grant(logic [1:0] mask);
        if (mask == 2'b11) return (served_any != 0) ? 1 - last_served : 0;
        return mask[1] ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one job to completion and reports what was observed
    task automatic run_job(input logic [1:0] vmask, input int lat, input int hold,
                           output int g, output int lat_obs, output int engcnt,
                           output logic [MB-1:0] x, output logic [MB-1:0] y,
                           output logic err, output logic id, output bit both,
                           output bit unstable, output bit resp_grant, output bit op_bad);
        g = -1; lat_obs = 0; engcnt = 0; x = '0; y = '0; err = 1'b0; id = 1'b0;
        both = 0; unstable = 0; resp_grant = 0; op_bad = 0;
        eng_lat = lat;
        rsp_ready = 1'b0;
        req_valid = vmask;
        #1;
        for (int i = 0; i < 40 && g < 0; i++) begin
            if (req_ready == 2'b11) both = 1;
            if (req_ready != 2'b00) g = req_ready[1] ? 1 : 0;
            else tick();
        end
        if (g < 0) return;
        tick();
        lat_obs = 1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready == 2'b11) both = 1;
            if (eng_valid) begin
                engcnt++;
                if (eng_px !== px_a[g] || eng_py !== py_a[g] || eng_k !== kk_a[g]) op_bad = 1;
            end
            if (rsp_valid) break;
            tick();
            lat_obs++;
        end
        x = rsp_x; y = rsp_y; err = rsp_err; id = rsp_id;
        for (int i = 0; i < hold; i++) begin
            if (req_ready != 2'b00) resp_grant = 1;
            tick();
            if (!rsp_valid || rsp_x !== x || rsp_y !== y || rsp_err !== err || rsp_id !== id)
                unstable = 1;
        end
        rsp_ready = 1'b1;
        #1;
        if (req_ready != 2'b00) resp_grant = 1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int g, lo, ec;
    logic [MB-1:0] ox, oy;
    logic oerr, oid;
    bit both, unst, rgr, opb;

    task automatic test_reset();
        rst = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_a = '0; cfg_b = '0; cfg_prime = '0;
        req_valid = 2'b11; rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            px_a[i] = '0; py_a[i] = '0; kk_a[i] = '0;
        end
        repeat (3) tick();
        n_total++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", req_ready); else n_pass++;
        n_total++; if ({busy, eng_valid, rsp_valid, rsp_err, rsp_id} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {busy, eng_valid, rsp_valid, rsp_err, rsp_id}); else n_pass++;
        n_total++; if ({eng_a, eng_k, rsp_x} !== '0) $display("FAIL reset_data: got nonzero want zero"); else n_pass++;
        n_total++; if (eng_mode !== 2'b00) $display("FAIL reset_mode: got %b want 00", eng_mode); else n_pass++;
        req_valid = 2'b00;
        rst = 1'b1;
        served_any = 0;
        tick();
    endtask

    task automatic test_round_robin();
        for (int j = 0; j < 4; j++) begin
            int lat, eg;
            for (int i = 0; i < 2; i++) begin
                px_a[i] = rand256(); py_a[i] = rand256(); kk_a[i] = rand256() | 256'd1;
            end
            lat = $urandom_range(1, 8);
            eg = m_grant(2'b11);
            run_job(2'b11, lat, 0, g, lo, ec, ox, oy, oerr, oid, both, unst, rgr, opb);
            n_total++; if (g != eg) $display("FAIL rr_grant job%0d: got %0d want %0d", j, g, eg); else n_pass++;
            n_total++; if (both) $display("FAIL rr_both_ready job%0d: got 11 want one-hot", j); else n_pass++;
            if (g >= 0) begin
                n_total++; if (ox !== m_x(px_a[g], kk_a[g], lat) || oerr !== 1'b0)
                    $display("FAIL rr_result job%0d: got x=%h err=%b", j, ox, oerr); else n_pass++;
                served_any = 1; last_served = g;
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_basic();
        cfg_valid = 1'b1; cfg_mode = 2'b00; cfg_a = 256'd2; cfg_b = 256'd3; cfg_prime = 256'd97;
        tick();
        cfg_valid = 1'b0;
        n_total++; if ({eng_mode, eng_a, eng_b, eng_prime} !== {2'b00, 256'd2, 256'd3, 256'd97})
            $display("FAIL cfg_load: got mode=%b a=%0d b=%0d p=%0d want 00/2/3/97", eng_mode, eng_a, eng_b, eng_prime); else n_pass++;
        px_a[0] = 256'd3; py_a[0] = 256'd6; kk_a[0] = 256'd2;
        eng_fixed = 1; fixed_x = 256'd80; fixed_y = 256'd10;
        run_job(2'b01, 10, 0, g, lo, ec, ox, oy, oerr, oid, both, unst, rgr, opb);
        eng_fixed = 0;
        req_valid = 2'b00;
        n_total++; if (g != 0) $display("FAIL basic_grant: got %0d want 0", g); else n_pass++;
        n_total++; if (lo != 11) $display("FAIL basic_latency: got %0d want 11", lo); else n_pass++;
        n_total++; if (ec != 10) $display("FAIL basic_eng_cycles: got %0d want 10", ec); else n_pass++;
        n_total++; if ({oid, oerr} !== 2'b00 || ox !== 256'd80 || oy !== 256'd10)
            $display("FAIL basic_result: got id=%b x=%0d y=%0d err=%b want 0/80/10/0", oid, ox, oy, oerr); else n_pass++;
        n_total++; if (opb) $display("FAIL basic_operands: engine operands differ from request"); else n_pass++;
        served_any = 1; last_served = 0;
        tick();
    endtask

    task automatic test_zero_k();
        spur_fin = 1'b1;
        tick();
        spur_fin = 1'b0;
        n_total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL idle_spurious_finish: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); else n_pass++;
        px_a[1] = rand256(); py_a[1] = rand256(); kk_a[1] = '0;
        run_job(2'b10, 5, 0, g, lo, ec, ox, oy, oerr, oid, both, unst, rgr, opb);
        req_valid = 2'b00;
        n_total++; if (g != 1 || oid !== 1'b1) $display("FAIL zk_id: got grant=%0d id=%b want 1", g, oid); else n_pass++;
        n_total++; if (lo != 1) $display("FAIL zk_latency: got %0d want 1", lo); else n_pass++;
        n_total++; if (ec != 0) $display("FAIL zk_eng_valid: got %0d cycles want 0", ec); else n_pass++;
        n_total++; if (ox !== '0 || oy !== '0 || oerr !== 1'b0) $display("FAIL zk_result: got x=%h err=%b want 0", ox, oerr); else n_pass++;
        served_any = 1; last_served = 1;
        tick();
    endtask

    task automatic test_timeout();
        int lats [4] = '{0, 15, 16, 17};
        for (int j = 0; j < 4; j++) begin
            px_a[0] = rand256(); py_a[0] = rand256(); kk_a[0] = rand256() | 256'd1;
            run_job(2'b01, lats[j], 0, g, lo, ec, ox, oy, oerr, oid, both, unst, rgr, opb);
            req_valid = 2'b00;
            n_total++; if (ec != m_engcnt(kk_a[0], lats[j]))
                $display("FAIL to_eng_cycles lat%0d: got %0d want %0d", lats[j], ec, m_engcnt(kk_a[0], lats[j])); else n_pass++;
            n_total++; if (lo != m_lat(kk_a[0], lats[j]))
                $display("FAIL to_latency lat%0d: got %0d want %0d", lats[j], lo, m_lat(kk_a[0], lats[j])); else n_pass++;
            n_total++; if (oerr !== m_timeout(kk_a[0], lats[j]) || ox !== m_x(px_a[0], kk_a[0], lats[j]) || oy !== m_y(py_a[0], kk_a[0], lats[j]))
                $display("FAIL to_result lat%0d: got err=%b x=%h", lats[j], oerr, ox); else n_pass++;
            served_any = 1; last_served = 0;
            tick();
        end
    endtask

    task automatic test_resp_hold();
        int eg;
        for (int i = 0; i < 2; i++) begin
            px_a[i] = rand256(); py_a[i] = rand256(); kk_a[i] = rand256() | 256'd1;
        end
        eg = m_grant(2'b11);
        run_job(2'b11, 3, 20, g, lo, ec, ox, oy, oerr, oid, both, unst, rgr, opb);
        req_valid = 2'b00;
        n_total++; if (unst) $display("FAIL hold_stable: got changing rsp_* want stable"); else n_pass++;
        n_total++; if (rgr) $display("FAIL hold_no_grant: got grant during RESP want none"); else n_pass++;
        n_total++; if (g != eg || ox !== m_x(px_a[eg], kk_a[eg], 3))
            $display("FAIL hold_result: got grant=%0d x=%h want grant=%0d", g, ox, eg); else n_pass++;
        if (g >= 0) begin served_any = 1; last_served = g; end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit saw_rsp = 0;
        kk_a[0] = rand256() | 256'd1;
        eng_lat = 0;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        cfg_valid = 1'b1; cfg_a = rand256() | 256'd4; cfg_mode = 2'b11;
        tick(); tick();
        cfg_valid = 1'b0;
        n_total++; if (eng_a !== 256'd2 || eng_valid !== 1'b1)
            $display("FAIL run_cfg_ignored: got a=%h eng_valid=%b want a=2 eng_valid=1", eng_a, eng_valid); else n_pass++;
        tick(); tick(); tick();
        req_valid = 2'b01;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if ({eng_valid, busy, req_ready} !== 4'b0000)
            $display("FAIL async_reset: got eng_valid=%b busy=%b ready=%b want 0", eng_valid, busy, req_ready); else n_pass++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b1;
        served_any = 0;
        cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_a = 256'd5; cfg_b = 256'd7; cfg_prime = 256'd101;
        tick();
        cfg_valid = 1'b0;
        n_total++; if ({eng_mode, eng_a, eng_prime} !== {2'b10, 256'd5, 256'd101})
            $display("FAIL cfg_after_reset: got mode=%b a=%0d p=%0d want 10/5/101", eng_mode, eng_a, eng_prime); else n_pass++;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid || busy) saw_rsp = 1;
            tick();
        end
        rsp_ready = 1'b0;
        n_total++; if (saw_rsp) $display("FAIL reset_discard: got response after reset want none"); else n_pass++;
    endtask

    task automatic test_random();
        for (int j = 0; j < 10; j++) begin
            logic [1:0] mask;
            int lat, hold, eg;
            mask = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                px_a[i] = rand256(); py_a[i] = rand256();
                kk_a[i] = ($urandom_range(0, 3) == 0) ? '0 : (rand256() | 256'd1);
            end
            lat = $urandom_range(1, 20);
            hold = $urandom_range(0, 3);
            eg = m_grant(mask);
            run_job(mask, lat, hold, g, lo, ec, ox, oy, oerr, oid, both, unst, rgr, opb);
            n_total++; if (g != eg) $display("FAIL rnd_grant job%0d: got %0d want %0d", j, g, eg); else n_pass++;
            if (g >= 0) begin
                n_total++; if (lo != m_lat(kk_a[g], lat))
                    $display("FAIL rnd_latency job%0d: got %0d want %0d", j, lo, m_lat(kk_a[g], lat)); else n_pass++;
                n_total++; if (ox !== m_x(px_a[g], kk_a[g], lat) || oy !== m_y(py_a[g], kk_a[g], lat) || oerr !== m_timeout(kk_a[g], lat))
                    $display("FAIL rnd_result job%0d: got x=%h err=%b", j, ox, oerr); else n_pass++;
                n_total++; if ((oid ? 1 : 0) != g) $display("FAIL rnd_id job%0d: got %b want %0d", j, oid, g); else n_pass++;
                n_total++; if (both || unst || rgr || opb)
                    $display("FAIL rnd_protocol job%0d: got both=%0d unstable=%0d resp_grant=%0d op_bad=%0d want 0", j, both, unst, rgr, opb); else n_pass++;
                served_any = 1; last_served = g;
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_zero_k();
        test_timeout();
        test_resp_hold();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ecc_job_scheduler.md
ECC_JOB_SCHEDULER -- requirements
Module: ecc_job_scheduler

Interface
REQ-001 SHALL have parameter MAX_BITS, default 256, giving the operand width.
REQ-002 SHALL have parameter TIMEOUT, default 1048575, giving the watchdog limit in cycles per job.
REQ-003 clk  in  1  clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cfg_valid  in  1  load curve configuration.
REQ-006 cfg_mode  in  2  width mode: 00=32, 01=64, 10=128, 11=256 bits.
REQ-007 cfg_a, cfg_b, cfg_prime  in  MAX_BITS each  curve coefficients and modulus.
REQ-008 req_valid  in  2  per-requester job request.
REQ-009 req_ready  out  2  per-requester accept.
REQ-010 req_px, req_py, req_k  in  2*MAX_BITS each  per-requester point x, point y and scalar; requester i occupies slice i.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  result consumed.
REQ-013 rsp_id  out  1  requester index of the result.
REQ-014 rsp_x, rsp_y  out  MAX_BITS each  result point.
REQ-015 rsp_err  out  1  job aborted by watchdog.
REQ-016 eng_valid  out  1  engine run level, held high for the whole computation.
REQ-017 eng_mode, eng_a, eng_b, eng_prime, eng_k, eng_px, eng_py  out  engine operands.
REQ-018 eng_finished  in  1  one-cycle engine completion pulse.
REQ-019 eng_outx, eng_outy  in  MAX_BITS each  engine result.
REQ-020 busy  out  1  state is not IDLE.

Function
REQ-021 SHALL implement the states IDLE, RUN and RESP, with at most one job outstanding.
REQ-022 SHALL register cfg_* on cfg_valid only in IDLE and ignore cfg_valid in any other state; eng_mode/a/b/prime SHALL be driven from these registers.
REQ-023 In IDLE, SHALL grant one valid requester using round-robin: if both are valid, grant the one not served last; after reset, requester 0 has priority.
REQ-024 req_ready SHALL be combinational: only the granted bit, only in IDLE, and never both bits at once.
REQ-025 On req_valid&req_ready, SHALL latch px/py/k and the id, then enter RUN on the next cycle.
REQ-026 If the latched k==0, SHALL bypass the engine and enter RESP with rsp_x=rsp_y=0 and rsp_err=0.
REQ-027 In RUN, eng_valid=1 and eng_px/py/k SHALL equal the latched values; the watchdog SHALL count from 0.
REQ-028 On eng_finished in RUN, SHALL capture eng_outx/outy into rsp_x/rsp_y, set rsp_err=0, and enter RESP.
REQ-029 If the watchdog reaches TIMEOUT-1 without eng_finished, SHALL enter RESP with rsp_x=rsp_y=0 and rsp_err=1.
REQ-030 If eng_finished and the timeout occur in the same cycle, finished SHALL win.
REQ-031 SHALL ignore eng_finished outside RUN.
REQ-032 In RESP, eng_valid=0 and rsp_valid=1; rsp_* SHALL hold stable until rsp_ready, then the block returns to IDLE and the round-robin pointer updates to rsp_id.
REQ-033 SHALL issue no grant during the rsp_ready cycle; the earliest next acceptance is the following cycle.
REQ-034 Latency: handshake at cycle T gives eng_valid high from T+1; eng_finished at cycle F gives rsp_valid from F+1.
REQ-035 Operands SHALL pass through unmodified, with no truncation by mode; mode only informs the engine.

Reset
REQ-036 On rst low, SHALL asynchronously force state=IDLE, eng_valid=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_id=0, busy=0, and all data, config, watchdog and pointer registers to 0.
REQ-037 Reset mid-RUN or mid-RESP SHALL discard the job without emitting any response.

Structure
REQ-038 Package ecc_pkg SHALL hold MAX_BITS, the mode encodings BITS32/64/128/256 and the scheduler state enum.
REQ-039 SHALL instantiate one sub-module, rr_arbiter2: a 2-way round-robin arbiter with last-grant register.

Verification
REQ-040 Config mode=00, a=2, b=3, prime=97; req0 with P=(3,6), k=2; engine model finishes after 10 cycles returning (80,10) -> rsp_valid 11 cycles after the handshake with id=0, (80,10), err=0.
REQ-041 Both requesters valid continuously for 4 jobs -> grant order 0,1,0,1 and req_ready never 2'b11.
REQ-042 req1 with k=0 -> rsp_valid at T+1 with (0,0), err=0, and eng_valid never asserted.
REQ-043 TIMEOUT=16 and engine never finishes -> eng_valid high for exactly 16 cycles, then rsp_err=1 with (0,0).
REQ-044 rsp_ready held low for 20 cycles with both requesters valid -> rsp_* stable throughout and no new grant.
REQ-045 rst asserted 5 cycles into RUN -> eng_valid=0 immediately, no response emitted, cfg_valid accepted on the next cycle after release.
